mult_seq: RTL and testbench
===========================

// Module: mult_seq
// PURPOSE
//  Control sequencer for the iterative shift-add multiplier (MULT) in the CPU.
//  Accepts a start pulse from the EX stage. Drives the multiplier datapath
//  strobes load / add / shift for WIDTH iterations, then reports completion.
//  Runs on the multiplier clock. Contains no operand or product storage;
//  it only inspects the current multiplier LSB that the datapath supplies.
// PARAMETERS
//  WIDTH   16   operand width in bits = number of iterations (>= 2)
//  CNT_W   $clog2(WIDTH)   iteration counter width (derived; do not override)
// PORTS
//  clk      in   1      multiplier clock; all state changes on posedge
//  rst      in   1      synchronous reset, active-high
//  start    in   1      request a multiply; sampled only in IDLE
//  lsb_b    in   1      current LSB of the multiplier shift register in MULT
//  load     out  1      MULT: load operands, clear accumulator
//  add      out  1      MULT: accumulator += multiplicand
//  shift    out  1      MULT: shift {acc, b} right by one
//  busy     out  1      high in every state except IDLE
//  done     out  1      one-cycle pulse: product valid in MULT
//  iter     out  CNT_W  index of the current iteration (0..WIDTH-1)
// BEHAVIOUR
//  - Reset: one clk with rst=1 forces IDLE and sets iter=0.
//    load, add, shift, busy and done are all 0 in IDLE.
//  - rst takes priority over all other inputs, in every state, including mid-operation.
//  - Moore FSM. All outputs decode from the state register only.
//    iter is a register.
//  - States: IDLE, LOAD, CHECK, ADD, SHIFT, DONE.
//  - IDLE:  start=1 -> LOAD; otherwise stay in IDLE.
//  - LOAD:  load=1, busy=1; iter<=0; -> CHECK.
//  - CHECK: busy=1, no strobes; lsb_b=1 -> ADD, lsb_b=0 -> SHIFT.
//  - ADD:   add=1, busy=1; -> SHIFT.
//  - SHIFT: shift=1, busy=1.
//      If iter==WIDTH-1 -> DONE, iter held.
//      Otherwise iter<=iter+1 -> CHECK.
//  - DONE:  done=1, busy=1 for exactly one cycle; -> IDLE. iter<=0.
//  - At most one of load/add/shift is high in any cycle.
//  - start is ignored while busy=1. It is not queued.
//    A start in the DONE cycle is lost.
//    The earliest restart is start=1 in the first IDLE cycle after DONE.
//  - lsb_b is sampled only in CHECK. Its value in other states is don't-care.
//  - Latency, counting the cycle where start is sampled in IDLE as cycle 0:
//      load is high in cycle 1.
//      done is high in cycle 2 + 2*WIDTH + popcount(b).
//  - Latency range for WIDTH=16: 34 cycles (b=0) to 50 cycles (b=0xFFFF).
//  - iter never exceeds WIDTH-1. iter does not wrap.
//  - Illegal or unused state encodings return to IDLE on the next clk.
// TESTING
//  1. rst=1 for 2 clk with start=1
//     -> IDLE held; load/add/shift/busy/done=0; iter=0.
//  2. WIDTH=16, start pulse, lsb_b=0 throughout
//     -> load in cycle 1; 16 shift pulses and 0 add pulses; done in cycle 34.
//  3. WIDTH=16, lsb_b=1 throughout
//     -> 16 add pulses, each followed by a shift pulse; done in cycle 50.
//  4. Drive lsb_b from a model of b=0x0005 shifting right
//     -> add pulses only at iter=0 and iter=2; done in cycle 36;
//        checker product matches 7*5=35 for a=7.
//  5. start held high continuously, and start=1 in the DONE cycle
//     -> no restart before IDLE; the next load comes 2 cycles after done.
//  6. rst=1 at iter=7 during SHIFT
//     -> next cycle IDLE, iter=0, no done pulse.
//     Then start -> full, correct sequence.

Source files
------------

// File: rtl/mult_seq.sv
// Control sequencer for the iterative shift-add multiplier.
// Steps load / (add) / shift strobes for WIDTH iterations, then pulses done.
module mult_seq #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lsb_b,
  output logic             load,
  output logic             add,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next state and iteration counter; lsb_b matters only in CHECK.
  always_comb begin
    state_d = S_IDLE;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        iter_d  = '0;
        state_d = S_CHECK;
      end
      S_CHECK: state_d = lsb_b ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        if (iter_q == LAST_ITER) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter_q + ONE;
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        iter_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        iter_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from the state register alone.
  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_LOAD:  begin load  = 1'b1; busy = 1'b1; end
      S_CHECK: begin busy  = 1'b1; end
      S_ADD:   begin add   = 1'b1; busy = 1'b1; end
      S_SHIFT: begin shift = 1'b1; busy = 1'b1; end
      S_DONE:  begin done  = 1'b1; busy = 1'b1; end
      default: begin end
    endcase
  end

  assign iter = iter_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: table of multiplies checked against a shift-add
// datapath model, plus reset, restart and mid-operation reset sequences.
module tb_mult_seq;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int BUDGET = 80;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             lsb_b;
  logic             load, add, shift, busy, done;
  logic [CNT_W-1:0] iter;

  mult_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .lsb_b (lsb_b),
    .load  (load),
    .add   (add),
    .shift (shift),
    .busy  (busy),
    .done  (done),
    .iter  (iter)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] b;
    logic [15:0] a;
    int          exp_done_cyc;
    int          exp_adds;
    logic [15:0] exp_mask;
    logic [31:0] exp_prod;
  } vec_t;

  // Results of the most recent run_mult call
  int          got_done_cyc, got_load_cyc, got_adds, got_shifts, got_viol;
  logic [15:0] got_mask;
  logic [31:0] got_prod;
  logic [32:0] dp;  // {acc[16:0], b[15:0]} datapath model

  // Starts a multiply and follows it until done (or budget). Leaves the bench
  // positioned in the done cycle. Cycle 0 is the edge that samples start.
  task automatic run_mult(input logic [15:0] b, input logic [15:0] a, input bit hold);
    int cyc;
    bit found;
    cyc = 0; found = 0;
    got_done_cyc = 0; got_load_cyc = 0; got_adds = 0; got_shifts = 0;
    got_viol = 0; got_mask = '0; dp = '0;
    start = 1'b1;
    lsb_b = 1'b0;
    while (!found && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) start = 1'b0;
      if ((int'(load) + int'(add) + int'(shift)) > 1) got_viol++;
      if (!busy) got_viol++;
      if (load) begin
        if (got_load_cyc == 0) got_load_cyc = cyc;
        dp = {17'd0, b};
      end
      if (add) begin
        got_adds++;
        got_mask[iter] = 1'b1;
        dp[32:16] = dp[32:16] + {1'b0, a};
      end
      if (shift) begin
        got_shifts++;
        dp = dp >> 1;
      end
      lsb_b = dp[0];
      if (done) begin
        found = 1;
        got_done_cyc = cyc;
      end
    end
    got_prod = dp[31:0];
    if (!found) $display("FAIL run_timeout: got=no_done expected=done_within_%0d", BUDGET);
  endtask

  task automatic check_run(input string tag, input vec_t v);
    check({tag, "_load_cyc"}, 64'(got_load_cyc), 64'd1);
    check({tag, "_done_cyc"}, 64'(got_done_cyc), 64'(v.exp_done_cyc));
    check({tag, "_adds"},     64'(got_adds),     64'(v.exp_adds));
    check({tag, "_shifts"},   64'(got_shifts),   64'd16);
    check({tag, "_add_mask"}, 64'(got_mask),     64'(v.exp_mask));
    check({tag, "_product"},  64'(got_prod),     64'(v.exp_prod));
    check({tag, "_viol"},     64'(got_viol),     64'd0);
    check({tag, "_iter_done"}, 64'(iter),        64'd15);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{b: 16'h0000, a: 16'h0003, exp_done_cyc: 34, exp_adds: 0,  exp_mask: 16'h0000, exp_prod: 32'h0000_0000};
    vecs[1] = '{b: 16'hFFFF, a: 16'h0001, exp_done_cyc: 50, exp_adds: 16, exp_mask: 16'hFFFF, exp_prod: 32'h0000_FFFF};
    vecs[2] = '{b: 16'h0005, a: 16'h0007, exp_done_cyc: 36, exp_adds: 2,  exp_mask: 16'h0005, exp_prod: 32'h0000_0023};
    vecs[3] = '{b: 16'h8001, a: 16'h0100, exp_done_cyc: 36, exp_adds: 2,  exp_mask: 16'h8001, exp_prod: 32'h0080_0100};
    vecs[4] = '{b: 16'h00FF, a: 16'h0203, exp_done_cyc: 42, exp_adds: 8,  exp_mask: 16'h00FF, exp_prod: 32'h0002_00FD};

    // Reset held two clocks with start asserted
    rst = 1'b1; start = 1'b1; lsb_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_outs", 64'({load, add, shift, busy, done}), 64'd0);
      check("rst_iter", 64'(iter), 64'd0);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("idle_quiet", 64'({load, add, shift, busy, done}), 64'd0);

    // Table-driven multiplies
    for (int i = 0; i < 5; i++) begin
      run_mult(vecs[i].b, vecs[i].a, 1'b0);
      check_run($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk); #1;
      check("after_done_idle", 64'({busy, done, iter}), 64'd0);
    end

    // start held continuously: no restart until IDLE, next load 2 after done
    run_mult(vecs[2].b, vecs[2].a, 1'b1);
    check_run("hold", vecs[2]);
    @(posedge clk); #1;
    check("hold_idle_busy", 64'({busy, load}), 64'd0);
    @(posedge clk); #1;
    check("hold_reload", 64'({busy, load}), 64'b11);
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // start only in the DONE cycle is lost
    run_mult(vecs[0].b, vecs[0].a, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_start_idle", 64'({busy, load}), 64'd0);
    @(posedge clk); #1;
    check("done_start_lost", 64'({busy, load}), 64'd0);

    // Reset at iter=7 during SHIFT
    begin
      int n;
      bit hit;
      n = 0; hit = 0;
      start = 1'b1; lsb_b = 1'b1;
      while (!hit && n < BUDGET) begin
        @(posedge clk); #1;
        n++;
        start = 1'b0;
        if (shift && iter == 4'd7) hit = 1;
      end
      check("mid_reached_iter7", 64'(hit), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_outs", 64'({load, add, shift, busy, done}), 64'd0);
      check("mid_rst_iter", 64'(iter), 64'd0);
      n = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (done || busy) n++;
      end
      check("mid_rst_no_done", 64'(n), 64'd0);
    end
    run_mult(vecs[4].b, vecs[4].a, 1'b0);
    check_run("post_rst", vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
